// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard receiver: synchronises and glitch-filters the bus, deframes 11-bit frames,
// folds E0/F0 prefixes into ext/brk flags and buffers codes in a first-word fall-through FIFO.
module ps2_kbd_decoder #(
  parameter int unsigned DEPTH_LOG2     = 3,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter bit          DECODE_PREFIX  = 1'b1
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  input  logic                  nextdata_n,
  output logic [7:0]            data,
  output logic                  ext,
  output logic                  brk,
  output logic                  ready,
  output logic                  overflow,
  output logic                  frame_err,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned FW    = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);

  // Input synchronisers and clock filter
  logic          kclk_s1_q, kclk_s2_q, kdat_s1_q, kdat_s2_q;
  logic          kclk_filt_q, kclk_filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          strobe;

  // Deframer
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          byte_vld_q, byte_vld_d;
  logic [7:0]    byte_q, byte_d;
  logic          frame_err_q, frame_err_d;

  // Prefix stage and FIFO
  logic          ext_pend_q, ext_pend_d;
  logic          brk_pend_q, brk_pend_d;
  logic [9:0]    mem_q [Depth];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;
  logic          overflow_q, overflow_d;
  logic          push, push_ok, pop, full;
  logic [9:0]    wdata;

  always_comb begin
    kclk_filt_d = kclk_filt_q;
    filt_cnt_d  = '0;
    // A new level is accepted only once it has been seen FILTER_LEN samples in a row.
    if (kclk_s2_q != kclk_filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        kclk_filt_d = kclk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end
  end

  assign strobe = kclk_filt_q & ~kclk_filt_d;

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tmo_d       = tmo_q;
    byte_vld_d  = 1'b0;
    byte_d      = byte_q;
    frame_err_d = 1'b0;
    if (strobe) begin
      tmo_d = '0;
      if (bit_cnt_q == 4'd10) begin
        // shift_q holds {parity, data[7:0], start}; the current sample is the stop bit.
        bit_cnt_d = 4'd0;
        if (!shift_q[0] && kdat_s2_q && (^shift_q[9:1])) begin
          byte_vld_d = 1'b1;
          byte_d     = shift_q[8:1];
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        shift_d   = {kdat_s2_q, shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt_d   = 4'd0;
        tmo_d       = '0;
        frame_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_comb begin
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    push       = 1'b0;
    wdata      = {ext_pend_q, brk_pend_q, byte_q};
    if (frame_err_q) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (byte_vld_q) begin
      if (DECODE_PREFIX && byte_q == 8'hE0) begin
        ext_pend_d = 1'b1;
      end else if (DECODE_PREFIX && byte_q == 8'hF0) begin
        brk_pend_d = 1'b1;
      end else begin
        push       = 1'b1;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end
  end

  always_comb begin
    pop        = ready_q & ~nextdata_n;
    full       = (count_q == CW'(Depth));
    // A pop in the same cycle frees the slot the push needs.
    push_ok    = push & (~full | pop);
    overflow_d = overflow_q | (push & full & ~pop);
    wr_ptr_d   = wr_ptr_q + PW'(push_ok);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + CW'(push_ok) - CW'(pop);
    ready_d    = (count_d != '0);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      kclk_s1_q   <= 1'b1;
      kclk_s2_q   <= 1'b1;
      kdat_s1_q   <= 1'b1;
      kdat_s2_q   <= 1'b1;
      kclk_filt_q <= 1'b1;
      filt_cnt_q  <= '0;
      bit_cnt_q   <= 4'd0;
      shift_q     <= '0;
      tmo_q       <= '0;
      byte_vld_q  <= 1'b0;
      byte_q      <= '0;
      frame_err_q <= 1'b0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      kclk_s1_q   <= ps2_clk;
      kclk_s2_q   <= kclk_s1_q;
      kdat_s1_q   <= ps2_data;
      kdat_s2_q   <= kdat_s1_q;
      kclk_filt_q <= kclk_filt_d;
      filt_cnt_q  <= filt_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tmo_q       <= tmo_d;
      byte_vld_q  <= byte_vld_d;
      byte_q      <= byte_d;
      frame_err_q <= frame_err_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign {ext, brk, data} = mem_q[rd_ptr_q];
  assign ready            = ready_q;
  assign overflow         = overflow_q;
  assign frame_err        = frame_err_q;
  assign count            = count_q;

endmodule
